// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: request side
// (start, operands, borrow-in) and completion side (busy, done, result).
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: d = a - b - bin, one bit per clock LSB
// first through a single full-subtractor cell, with start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, acc, acc_next, d_q;
  logic [CW-1:0]    cnt;
  logic             br, bout_q, done_q;
  logic             diff, borrow, last, accept;

  // Full-subtractor cell on the current LSB pair and registered borrow
  always_comb begin
    diff     = sa[0] ^ sb[0] ^ br;
    borrow   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    acc_next = {diff, acc[WIDTH-1:1]};
    last     = (cnt == LAST);
    accept   = bus.start && ((state == IDLE) || (state == DONE));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a start in DONE is taken immediately for back-to-back use
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand load, per-bit shift, and result capture on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      br     <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == RUN) && last;
      if (accept) begin
        sa  <= bus.a;
        sb  <= bus.b;
        br  <= bus.bin;
        acc <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        br  <= borrow;
        acc <= acc_next;
        if (last) begin
          d_q    <= acc_next;
          bout_q <= borrow;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Outputs straight from registers
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = done_q;
    bus.d    = d_q;
    bus.bout = bout_q;
  end
endmodule
